display_matrix_scanner: RTL



---
 rtl/display_pkg.sv | 26 ++
 rtl/display_scan_timer.sv | 64 ++++++
 rtl/display_matrix_scanner.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants, channel-index type and width helpers for the LED-matrix scanner.
package display_pkg;

  localparam int unsigned CHAN_IDX_W = 4;

  typedef logic [CHAN_IDX_W-1:0] chan_idx_t;

  localparam chan_idx_t SIDE_RED   = CHAN_IDX_W'(0);
  localparam chan_idx_t SIDE_GREEN = CHAN_IDX_W'(1);

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = int'(i + 1);
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned width_of(input int unsigned v);
    return (clog2(v) == 0) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Row-period phase counter and row index; strobes describe the cycle that starts at the next edge.
module display_scan_timer
  import display_pkg::*;
#(
  parameter int unsigned ROWS         = 8,
  parameter int unsigned COLS         = 8,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 2,
  localparam int unsigned ROW_W = width_of(ROWS),
  localparam int unsigned COL_W = width_of(COLS),
  localparam int unsigned CNT_W = width_of(SCAN_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [ROW_W-1:0] row_c,
  output logic [ROW_W-1:0] fetch_row_c,
  output logic             blank_c,
  output logic             load_cols_c,
  output logic             fetch_valid_c,
  output logic [COL_W-1:0] fetch_col_c
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ROW_W-1:0] row, row_nxt;

  always_comb begin
    cnt_nxt = cnt;
    row_nxt = row;
    if (!en) begin
      cnt_nxt = '0;
      row_nxt = LAST_ROW;
    end else if (cnt == CNT_W'(SCAN_DIV - 1)) begin
      cnt_nxt = '0;
      row_nxt = (row == LAST_ROW) ? '0 : row + ROW_W'(1);
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      row <= LAST_ROW;
    end else begin
      cnt <= cnt_nxt;
      row <= row_nxt;
    end
  end

  // Decode from next-state so downstream registers line up with cnt.
  always_comb begin
    row_c         = row_nxt;
    fetch_row_c   = (row_nxt == LAST_ROW) ? '0 : row_nxt + ROW_W'(1);
    blank_c       = cnt_nxt < CNT_W'(BLANK_CYCLES);
    load_cols_c   = cnt_nxt == CNT_W'(BLANK_CYCLES);
    fetch_valid_c = (cnt_nxt >= CNT_W'(BLANK_CYCLES + 1)) &&
                    (cnt_nxt <= CNT_W'(BLANK_CYCLES + COLS));
    fetch_col_c   = COL_W'(cnt_nxt - CNT_W'(BLANK_CYCLES + 1));
  end

endmodule

// File: rtl/display_matrix_scanner.sv
// Multiplexed LED-matrix scan engine: fetches the next row from frame RAM,
// patches flicker per channel into a staging buffer, and drives one active-low row.
module display_matrix_scanner
  import display_pkg::*;
#(
  parameter int unsigned ROWS         = 8,
  parameter int unsigned COLS         = 8,
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 2,
  localparam int unsigned ADDR_W = width_of(ROWS * COLS),
  localparam int unsigned CHAN_W = width_of(CHANNELS),
  localparam int unsigned LED_W  = CHANNELS * COLS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                flicker_state,
  input  logic                screen_flicker_en,
  input  logic                point_flicker_en,
  input  logic [ADDR_W-1:0]   point_flicker_pos,
  input  logic [CHAN_W-1:0]   point_flicker_chan,
  input  logic [CHANNELS-1:0] chan_flicker_mask,
  output logic [ADDR_W-1:0]   ram_rd_addr,
  input  logic [CHANNELS-1:0] ram_data,
  output logic [ROWS-1:0]     led_row,
  output logic [LED_W-1:0]    led_col
);

  localparam int unsigned ROW_W = width_of(ROWS);
  localparam int unsigned COL_W = width_of(COLS);

  logic [ROW_W-1:0]    row_c, fetch_row_c;
  logic                blank_c, load_cols_c, fetch_valid_c;
  logic [COL_W-1:0]    fetch_col_c;

  logic                addr_vld_q, cap_q;
  logic [COL_W-1:0]    col_q, cap_col;
  logic [ADDR_W-1:0]   cap_addr;
  logic [LED_W-1:0]    staging;

  logic [ADDR_W-1:0]   addr_nxt;
  logic [CHANNELS-1:0] px;
  logic                point_hit;
  logic [LED_W-1:0]    staging_nxt;
  logic [ROWS-1:0]     led_row_nxt;

  display_scan_timer #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .row_c         (row_c),
    .fetch_row_c   (fetch_row_c),
    .blank_c       (blank_c),
    .load_cols_c   (load_cols_c),
    .fetch_valid_c (fetch_valid_c),
    .fetch_col_c   (fetch_col_c)
  );

  always_comb begin
    addr_nxt = ram_rd_addr;
    if (fetch_valid_c) addr_nxt = ADDR_W'(int'(fetch_row_c) * COLS + int'(fetch_col_c));
  end

  // Flicker patch on the returned pixel; cap_addr is the address that produced ram_data.
  always_comb begin
    px        = '0;
    point_hit = point_flicker_en && (cap_addr == point_flicker_pos);
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (screen_flicker_en) begin
        if (ch == int'(SIDE_RED))      px[ch] = flicker_state;
        else if (ch == CHANNELS - 1)   px[ch] = ~flicker_state;
        else                           px[ch] = 1'b0;
      end else if (point_hit) begin
        px[ch] = (CHAN_W'(ch) == point_flicker_chan) ? flicker_state : ram_data[ch];
      end else begin
        px[ch] = (chan_flicker_mask[ch] && ram_data[ch]) ? flicker_state : ram_data[ch];
      end
    end
  end

  always_comb begin
    staging_nxt = staging;
    if (cap_q) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        for (int c = 0; c < COLS; c++) begin
          if (COL_W'(c) == cap_col) staging_nxt[ch*COLS + c] = px[ch];
        end
      end
    end
  end

  always_comb begin
    led_row_nxt = '1;
    for (int r = 0; r < ROWS; r++) begin
      led_row_nxt[r] = blank_c || (ROW_W'(r) != row_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_row     <= '1;
      led_col     <= '0;
      ram_rd_addr <= '0;
      staging     <= '0;
      addr_vld_q  <= 1'b0;
      col_q       <= '0;
      cap_q       <= 1'b0;
      cap_col     <= '0;
      cap_addr    <= '0;
    end else if (!en) begin
      led_row     <= '1;
      led_col     <= '0;
      ram_rd_addr <= '0;
      staging     <= '0;
      addr_vld_q  <= 1'b0;
      col_q       <= '0;
      cap_q       <= 1'b0;
      cap_col     <= '0;
      cap_addr    <= '0;
    end else begin
      led_row     <= led_row_nxt;
      if (blank_c)          led_col <= '0;
      else if (load_cols_c) led_col <= staging;
      ram_rd_addr <= addr_nxt;
      addr_vld_q  <= fetch_valid_c;
      col_q       <= fetch_col_c;
      cap_q       <= addr_vld_q;
      cap_col     <= col_q;
      cap_addr    <= ram_rd_addr;
      staging     <= staging_nxt;
    end
  end

endmodule
